// File: rtl/ds_burst_frame_assembler.sv
// Downstream burst frame assembler: reassembles analysis-stage beats into
// ping-pong frame banks and replays committed frames over valid/ready.
module ds_burst_frame_assembler #(
  parameter int BANK_DEPTH  = 64,
  parameter int GAP_TIMEOUT = 256,
  parameter int CNT_W       = 16
) (
  input  logic             sys_clk_i,
  input  logic             rst_i,
  input  logic             ds_burst_valid_i,
  input  logic [127:0]     ds_burst_data_i,
  input  logic [7:0]       src_id_i,
  input  logic [7:0]       des_id_i,
  input  logic [7:0]       data_channel_i,
  input  logic [15:0]      data_field_len_i,
  output logic             m_valid_o,
  input  logic             m_ready_i,
  output logic [127:0]     m_data_o,
  output logic             m_last_o,
  output logic [4:0]       m_last_bytes_o,
  output logic [7:0]       m_src_id_o,
  output logic [7:0]       m_des_id_o,
  output logic [7:0]       m_channel_o,
  output logic [15:0]      m_len_o,
  output logic [CNT_W-1:0] drop_full_cnt_o,
  output logic [CNT_W-1:0] drop_size_cnt_o,
  output logic [CNT_W-1:0] timeout_cnt_o,
  output logic [CNT_W-1:0] frame_cnt_o
);

  localparam int AW = $clog2(BANK_DEPTH);
  localparam int GW = $clog2(GAP_TIMEOUT + 1);
  localparam logic [16:0] MAX_LEN = 17'(BANK_DEPTH * 16);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_TIMEOUT - 1);

  typedef enum logic [1:0] {
    W_IDLE,
    W_FILL,
    W_DROP
  } w_state_t;

  typedef enum logic {
    R_IDLE,
    R_SEND
  } r_state_t;

  typedef struct packed {
    logic [7:0]  src;
    logic [7:0]  des;
    logic [7:0]  ch;
    logic [15:0] len;
  } desc_t;

  function automatic logic [16:0] beats_of(input logic [15:0] len);
    return ({1'b0, len} + 17'd15) >> 4;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v,
    input logic             en
  );
    return (en && v != '1) ? v + CNT_W'(1) : v;
  endfunction

  logic [127:0]  mem [2*BANK_DEPTH];
  desc_t         desc_q [2];
  logic [1:0]    full_q;
  logic [1:0]    full_d;
  logic          wr_bank_q;
  logic          rd_bank_q;

  w_state_t      w_state_q;
  w_state_t      w_state_d;
  logic [16:0]   w_idx_q;
  logic [16:0]   w_idx_d;
  logic [16:0]   w_nb_q;
  logic [16:0]   w_nb_d;
  logic [GW-1:0] gap_q;
  logic [GW-1:0] gap_d;
  logic [16:0]   in_nb;
  logic [AW-1:0] w_addr;
  logic          wr_free;
  logic          mem_we;
  logic          desc_we;
  logic          commit;
  logic          inc_size;
  logic          inc_full;
  logic          inc_to;

  r_state_t      r_state_q;
  r_state_t      r_state_d;
  logic [16:0]   r_idx_q;
  logic [16:0]   r_idx_d;
  logic [16:0]   r_nb;
  logic [16:0]   issue_idx;
  logic [AW:0]   raddr;
  desc_t         r_desc;
  logic          issue;
  logic          issue_last;
  logic          start;
  logic          pop;
  logic          rel;

  logic          o_v_q;
  logic          o_l_q;
  logic [127:0]  o_d_q;
  logic          s_v_q;
  logic          s_l_q;
  logic [127:0]  s_d_q;

  assign in_nb   = beats_of(data_field_len_i);
  assign pop     = o_v_q && m_ready_i;
  assign rel     = pop && o_l_q;
  // A bank drained this very cycle can take the next frame
  assign wr_free = !full_q[wr_bank_q] ||
                   (rel && rd_bank_q == wr_bank_q);

  always_comb begin
    w_state_d = w_state_q;
    w_idx_d   = w_idx_q;
    w_nb_d    = w_nb_q;
    gap_d     = gap_q;
    w_addr    = w_idx_q[AW-1:0];
    mem_we    = 1'b0;
    desc_we   = 1'b0;
    commit    = 1'b0;
    inc_size  = 1'b0;
    inc_full  = 1'b0;
    inc_to    = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        gap_d  = '0;
        w_addr = '0;
        if (ds_burst_valid_i && data_field_len_i != 16'd0) begin
          w_nb_d  = in_nb;
          w_idx_d = 17'd1;
          if ({1'b0, data_field_len_i} > MAX_LEN) begin
            inc_size = 1'b1;
            if (in_nb > 17'd1) w_state_d = W_DROP;
          end else if (!wr_free) begin
            inc_full = 1'b1;
            if (in_nb > 17'd1) w_state_d = W_DROP;
          end else begin
            mem_we  = 1'b1;
            desc_we = 1'b1;
            if (in_nb == 17'd1) commit = 1'b1;
            else w_state_d = W_FILL;
          end
        end
      end
      W_FILL, W_DROP: begin
        if (ds_burst_valid_i) begin
          gap_d  = '0;
          mem_we = (w_state_q == W_FILL);
          if (w_idx_q == w_nb_q - 17'd1) begin
            commit    = (w_state_q == W_FILL);
            w_state_d = W_IDLE;
          end else begin
            w_idx_d = w_idx_q + 17'd1;
          end
        end else if (gap_q == GAP_LAST) begin
          inc_to    = (w_state_q == W_FILL);
          gap_d     = '0;
          w_state_d = W_IDLE;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    full_d = full_q;
    if (rel)    full_d[rd_bank_q] = 1'b0;
    if (commit) full_d[wr_bank_q] = 1'b1;
  end

  always_ff @(posedge sys_clk_i) begin
    if (mem_we) mem[{wr_bank_q, w_addr}] <= ds_burst_data_i;
  end

  always_ff @(posedge sys_clk_i) begin
    if (rst_i) begin
      w_state_q       <= W_IDLE;
      w_idx_q         <= '0;
      w_nb_q          <= '0;
      gap_q           <= '0;
      wr_bank_q       <= 1'b0;
      full_q          <= '0;
      desc_q[0]       <= '0;
      desc_q[1]       <= '0;
      drop_full_cnt_o <= '0;
      drop_size_cnt_o <= '0;
      timeout_cnt_o   <= '0;
    end else begin
      w_state_q       <= w_state_d;
      w_idx_q         <= w_idx_d;
      w_nb_q          <= w_nb_d;
      gap_q           <= gap_d;
      full_q          <= full_d;
      drop_full_cnt_o <= sat_inc(drop_full_cnt_o, inc_full);
      drop_size_cnt_o <= sat_inc(drop_size_cnt_o, inc_size);
      timeout_cnt_o   <= sat_inc(timeout_cnt_o, inc_to);
      if (commit) wr_bank_q <= ~wr_bank_q;
      if (desc_we) begin
        desc_q[wr_bank_q] <= '{src: src_id_i,
                               des: des_id_i,
                               ch:  data_channel_i,
                               len: data_field_len_i};
      end
    end
  end

  assign r_desc = desc_q[rd_bank_q];
  assign r_nb   = beats_of(r_desc.len);

  // Beat 0 is fetched in the cycle the full flag is first seen
  always_comb begin
    r_state_d = r_state_q;
    r_idx_d   = r_idx_q;
    issue     = 1'b0;
    issue_idx = r_idx_q;
    start     = 1'b0;
    if (r_state_q == R_IDLE) begin
      if (full_q[rd_bank_q]) begin
        start     = 1'b1;
        issue     = 1'b1;
        issue_idx = '0;
        r_idx_d   = 17'd1;
        r_state_d = R_SEND;
      end
    end else begin
      if (r_idx_q < r_nb && !s_v_q) begin
        issue   = 1'b1;
        r_idx_d = r_idx_q + 17'd1;
      end
      if (rel) r_state_d = R_IDLE;
    end
    issue_last = (issue_idx == r_nb - 17'd1);
    raddr      = {rd_bank_q, issue_idx[AW-1:0]};
  end

  always_ff @(posedge sys_clk_i) begin
    if (rst_i) begin
      r_state_q      <= R_IDLE;
      r_idx_q        <= '0;
      rd_bank_q      <= 1'b0;
      o_v_q          <= 1'b0;
      o_l_q          <= 1'b0;
      o_d_q          <= '0;
      s_v_q          <= 1'b0;
      s_l_q          <= 1'b0;
      s_d_q          <= '0;
      m_src_id_o     <= '0;
      m_des_id_o     <= '0;
      m_channel_o    <= '0;
      m_len_o        <= '0;
      m_last_bytes_o <= '0;
      frame_cnt_o    <= '0;
    end else begin
      r_state_q   <= r_state_d;
      r_idx_q     <= r_idx_d;
      frame_cnt_o <= sat_inc(frame_cnt_o, rel);
      if (rel) rd_bank_q <= ~rd_bank_q;
      if (start) begin
        m_src_id_o     <= r_desc.src;
        m_des_id_o     <= r_desc.des;
        m_channel_o    <= r_desc.ch;
        m_len_o        <= r_desc.len;
        m_last_bytes_o <= (r_desc.len[3:0] == 4'd0) ?
                          5'd16 : {1'b0, r_desc.len[3:0]};
      end
      // Skid never holds data when a fetch is issued
      if (!o_v_q || pop) begin
        if (s_v_q) begin
          o_v_q <= 1'b1;
          o_d_q <= s_d_q;
          o_l_q <= s_l_q;
          s_v_q <= 1'b0;
        end else if (issue) begin
          o_v_q <= 1'b1;
          o_d_q <= mem[raddr];
          o_l_q <= issue_last;
        end else begin
          o_v_q <= 1'b0;
          o_l_q <= 1'b0;
        end
      end else if (issue) begin
        s_v_q <= 1'b1;
        s_d_q <= mem[raddr];
        s_l_q <= issue_last;
      end
    end
  end

  assign m_valid_o = o_v_q;
  assign m_data_o  = o_d_q;
  assign m_last_o  = o_l_q;

endmodule

// File: doc/ds_burst_frame_assembler.md
Name: ds_burst_frame_assembler

Overview:
- Sits directly downstream of the message receive/analysis stage and consumes its downstream-burst stream: 128-bit beats plus the registered header fields (src id, dest id, data channel, data field length).
- Reassembles each burst message into one of two ping-pong frame banks.
- Replays each committed frame to the DS burst consumer over a valid/ready stream with a frame descriptor.
- Drops oversize, overflowing and stalled frames, and counts every drop.

Parameters:
- BANK_DEPTH, 64, beats per bank (max frame = BANK_DEPTH*16 bytes); power of 2.
- GAP_TIMEOUT, 256, idle cycles allowed between beats inside a frame before abort.
- CNT_W, 16, width of the saturating status counters.

Ports:
- sys_clk_i  in  1  single clock.
- rst_i  in  1  synchronous reset, active-high.
- ds_burst_valid_i  in  1  beat strobe from analysis stage.
- ds_burst_data_i  in  128  beat data.
- src_id_i  in  8  source id, aligned with beats.
- des_id_i  in  8  destination id, aligned.
- data_channel_i  in  8  data channel, aligned.
- data_field_len_i  in  16  frame payload length in bytes, aligned.
- m_valid_o  out  1  output beat valid.
- m_ready_i  in  1  downstream ready.
- m_data_o  out  128  output beat.
- m_last_o  out  1  last beat of frame.
- m_last_bytes_o  out  5  valid bytes in last beat (1..16); only meaningful with m_last_o.
- m_src_id_o, m_des_id_o, m_channel_o  out  8 each  descriptor; held for the whole frame.
- m_len_o  out  16  frame byte length; held for the whole frame.
- drop_full_cnt_o  out  CNT_W  frames dropped because no bank was free.
- drop_size_cnt_o  out  CNT_W  frames dropped because the length was oversize.
- timeout_cnt_o  out  CNT_W  frames aborted on gap timeout.
- frame_cnt_o  out  CNT_W  frames fully delivered.

Behaviour:
- Reset: all outputs are 0; both banks are empty; the write and read pointers select bank 0; the FSMs go to W_IDLE and R_IDLE. Reset mid-frame discards all stored data.
- Beat count: nbeats = (len+15)>>4, computed with 17-bit arithmetic. last_bytes = len[3:0]==0 ? 16 : len[3:0].
- The write FSM has three states: W_IDLE, W_FILL and W_DROP.
- W_IDLE, valid with len==0: the beat is ignored and the FSM stays in W_IDLE.
- W_IDLE, valid with len>BANK_DEPTH*16: drop_size_cnt increments. If nbeats>1, go to W_DROP; otherwise stay in W_IDLE.
- W_IDLE, valid with the write bank full: drop_full_cnt increments. Go to W_DROP, or stay in W_IDLE if nbeats==1.
- W_IDLE, valid otherwise: latch the header into the bank descriptor and write beat 0. If nbeats==1, commit immediately; else go to W_FILL.
- Bank free check: a bank being released by the read side in the same cycle counts as free.
- W_FILL: each valid beat is written at the beat index, which is then incremented. On beat nbeats-1, commit: set bank full, toggle the write bank, go to W_IDLE.
- W_DROP: beats are counted but not stored. After nbeats, return to W_IDLE.
- Gap timeout: in W_FILL or W_DROP, a gap counter resets on every valid beat and increments otherwise. At GAP_TIMEOUT, the frame is aborted: timeout_cnt increments (W_FILL only), the bank is not committed, and the FSM returns to W_IDLE.
- The read FSM has two states: R_IDLE and R_SEND.
- R_IDLE: when the read bank is full, go to R_SEND.
- Memory read latency is 1 cycle. The first m_valid_o rises 2 cycles after commit, using a prefetch register plus an output skid register so the stream stays full-rate under ready toggling.
- Handshake: a beat transfers when m_valid_o && m_ready_i. m_data_o and m_last_o are held stable while m_valid_o && !m_ready_i.
- Last beat: m_last_o is asserted on beat nbeats-1. When the last beat transfers: clear the bank full flag, toggle the read bank, increment frame_cnt, return to R_IDLE.
- Back-to-back frames: the next frame's first beat may follow one idle cycle.
- Frame order: frames are delivered strictly in commit order.
- Counters saturate at all-ones and never wrap.
- Simultaneous commit and release on different banks are both honoured in the same cycle.

Test Plan:
- Single frame, len=40, 3 beats 0xA..0xC, m_ready=1 -> 3 output beats; m_last on beat 3; m_last_bytes=8; m_len=40; frame_cnt=1.
- len=16, 1 beat -> commit on the same cycle; one output beat with m_last=1 and m_last_bytes=16.
- m_ready held 0 while frames of len 64, 64 and 64 arrive -> first two are stored; third raises drop_full_cnt=1. After releasing ready, exactly 8 beats emerge in order.
- len=1040 with BANK_DEPTH=64 -> drop_size_cnt=1; its 65 beats are swallowed; the next len=32 frame is delivered intact.
- len=48, 2 beats then 256 idle cycles -> timeout_cnt=1 and no output. A following len=16 frame is delivered into the same bank.
- Random m_ready (50%) over 100 frames of random len 1..1024 -> output data, order and descriptors match a scoreboard; frame_cnt=100. Also assert rst_i mid-frame -> all outputs 0 next cycle and no partial frame is emitted afterwards.
